// File: rtl/fifo_frame_reader_pkg.sv
// Shared constants for the frame reader: FSM encoding, default frame size, derived widths.
// Pure declarations; no latency or flow control of its own.
package fifo_frame_reader_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int FRAME_LEN_DEF = 64;

   // Index port is fixed at 6 bits so frame sizes up to 64 share one interface.
   localparam int IDX_W = ($clog2(FRAME_LEN_DEF) > 6) ? $clog2(FRAME_LEN_DEF) : 6;
   localparam int CNT_W = IDX_W + 1;

   // Guard bits so 64 full-scale samples cannot overflow the accumulator.
   localparam int SUM_GUARD = 6;

endpackage

// File: rtl/fifo_frame_reader_frame_out_reg.sv
// Output hold register for data/valid/tags; loads on pop, clears valid on transfer.
// Zero extra latency beyond the load edge; contents held stable while downstream stalls.
module frame_out_reg
   import fifo_frame_reader_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic              first_i,
   input  logic              last_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              valid_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              first_o,
   output logic              last_o
);

   logic [DWIDTH-1:0] data_q;
   logic              valid_q;
   logic [IDX_W-1:0]  idx_q;
   logic              first_q;
   logic              last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
         idx_q   <= idx_i;
         first_q <= first_i;
         last_q  <= last_i;
      end else if (unload_i) begin
         valid_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign idx_o   = idx_q;
   assign first_o = first_q;
   assign last_o  = last_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains one full frame from an upstream FIFO into a valid/ready stream and sums its samples.
// Pop-to-valid at the same edge, one sample/cycle; pops stop while m_valid is held by m_ready=0.
module fifo_frame_reader
   import fifo_frame_reader_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fifo_full,
   input  logic                         fifo_error,
   input  logic [DWIDTH-1:0]            fifo_data,
   output logic                         fifo_rd_ce,
   output logic [DWIDTH-1:0]            m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_first,
   output logic                         m_last,
   output logic [IDX_W-1:0]             m_index,
   output logic signed [DWIDTH+5:0]     frame_sum,
   output logic                         sum_valid,
   output logic                         busy,
   output logic                         err,
   input  logic                         err_clr
);

   localparam int SUM_W = DWIDTH + SUM_GUARD;

   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [SUM_W-1:0] acc_q, acc_d;
   logic signed [SUM_W-1:0] frame_sum_q, frame_sum_d;
   logic                    sum_valid_q, sum_valid_d;
   logic                    err_q, err_d;
   logic                    pop;
   logic                    xfer;
   logic signed [SUM_W-1:0] beat_ext;

   assign xfer     = m_valid && m_ready;
   assign pop      = (state_q == ST_DRAIN) && (cnt_q < CNT_W'(FRAME_LEN)) && (!m_valid || m_ready);
   assign beat_ext = {{SUM_GUARD{m_data[DWIDTH-1]}}, m_data};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      frame_sum_d = frame_sum_q;
      sum_valid_d = 1'b0;
      if (xfer) acc_d = acc_q + beat_ext;
      if (pop) cnt_d = cnt_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (fifo_full) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (pop && (cnt_q == CNT_W'(FRAME_LEN - 1))) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            // Sum includes the final beat, which transfers on this same edge.
            if (xfer && m_last) begin
               state_d     = ST_DONE;
               frame_sum_d = acc_d;
               sum_valid_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (fifo_error || ((state_q == ST_FLUSH) && fifo_full)) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         frame_sum_q <= '0;
         sum_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         frame_sum_q <= frame_sum_d;
         sum_valid_q <= sum_valid_d;
         err_q       <= err_d;
      end
   end

   frame_out_reg #(
      .DWIDTH (DWIDTH)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .load_i   (pop),
      .unload_i (xfer),
      .data_i   (fifo_data),
      .idx_i    (cnt_q[IDX_W-1:0]),
      .first_i  (cnt_q == '0),
      .last_i   (cnt_q == CNT_W'(FRAME_LEN - 1)),
      .data_o   (m_data),
      .valid_o  (m_valid),
      .idx_o    (m_index),
      .first_o  (m_first),
      .last_o   (m_last)
   );

   assign fifo_rd_ce = pop;
   assign frame_sum  = frame_sum_q;
   assign sum_valid  = sum_valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign err        = err_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench: models the upstream FIFO head and a stalling sink, checks beats, sums and flags.
module tb_fifo_frame_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_full, fifo_error, fifo_rd_ce;
   logic [31:0] fifo_data, m_data;
   logic        m_valid, m_ready, m_first, m_last;
   logic [5:0]  m_index;
   logic [37:0] frame_sum;
   logic        sum_valid, busy, err, err_clr;

   int npass = 0, ntot = 0;
   int rp = 0, fbase = 0, kind = 0, pat = 0, cyc = 0;
   int hold_full = 0, loaded = 0, err_at = -1;
   int exp_k = 0, nsum = 0, fpops = 0, fcyc = 0;
   logic        pop_pend = 1'b0, prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic [5:0]  prev_idx = '0;
   logic [37:0] msum = '0;

   always #5 clk = ~clk;

   fifo_frame_reader #(.DWIDTH(32), .FRAME_LEN(64)) dut (
      .clk(clk), .rst(rst), .fifo_full(fifo_full), .fifo_error(fifo_error),
      .fifo_data(fifo_data), .fifo_rd_ce(fifo_rd_ce), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_first(m_first), .m_last(m_last), .m_index(m_index),
      .frame_sum(frame_sum), .sum_valid(sum_valid), .busy(busy), .err(err), .err_clr(err_clr)
   );

   function automatic logic [31:0] dfun(input int k, input int p);
      case (k)
         0:       dfun = 32'(p % 64 + 1);
         1:       dfun = 32'h8000_0000;
         default: dfun = 32'(p * 32'h0123_4567) ^ 32'hA5A5_0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One cycle: advance FIFO head for last pop, drive inputs, then check the settled outputs.
   task automatic tick();
      @(negedge clk);
      if (pop_pend) begin
         rp++;
         fpops++;
      end
      fifo_data  = dfun(kind, rp);
      fifo_full  = (hold_full != 0) || ((loaded != 0) && (rp == fbase));
      fifo_error = (fcyc == err_at);
      err_clr    = 1'b0;
      m_ready    = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      cyc++;
      fcyc++;
      #1;
      if (prev_stall) begin
         chk("stall_data", m_data, prev_data);
         chk("stall_idx", m_index, prev_idx);
      end
      prev_stall = m_valid && !m_ready;
      if (prev_stall) begin
         chk("stall_no_pop", fifo_rd_ce, 0);
         prev_data = m_data;
         prev_idx  = m_index;
      end
      if (m_valid && m_ready) begin
         chk("beat_data", m_data, dfun(kind, fbase + exp_k));
         chk("beat_idx", m_index, exp_k);
         chk("beat_first", m_first, exp_k == 0);
         chk("beat_last", m_last, exp_k == 63);
         msum = msum + {{6{m_data[31]}}, m_data};
         exp_k++;
      end
      if (sum_valid) begin
         nsum++;
         chk("sum_model", frame_sum, msum);
         chk("sum_after_all_beats", exp_k, 64);
      end
      pop_pend = fifo_rd_ce;
   endtask

   task automatic run_frame(input int stop_at);
      exp_k = 0; nsum = 0; fpops = 0; fcyc = 0; msum = '0;
      fbase = rp; loaded = 1;
      for (int i = 0; i < 1000 && nsum == 0; i++) begin
         tick();
         if (stop_at > 0 && exp_k == stop_at) return;
      end
      tick();
      chk("sum_pulses", nsum, 1);
      chk("idle_gap_busy", busy, 0);
      chk("idle_gap_no_pop", fifo_rd_ce, 0);
      chk("frame_pops", fpops, 64);
      loaded = 0;
   endtask

   initial begin
      rst = 1'b1; fifo_full = 1'b0; fifo_error = 1'b0; err_clr = 1'b0;
      m_ready = 1'b0; fifo_data = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rd_ce", fifo_rd_ce, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_index", m_index, 0);
      chk("rst_sum", frame_sum, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      repeat (3) tick();
      chk("idle_no_full", busy, 0);

      // Ramp 1..64, sink always ready.
      kind = 0; pat = 0; run_frame(0);
      chk("ramp_sum", frame_sum, 38'd2080);
      chk("ramp_no_err", err, 0);

      // Mixed-sign data with ready pattern 1,0,0,1.
      kind = 2; pat = 1; run_frame(0);

      // Full-scale negative samples.
      kind = 1; pat = 0; run_frame(0);
      chk("neg_sum", frame_sum, 38'h20_0000_0000);

      // Error pulse mid-drain; frame still completes and err is sticky.
      kind = 0; err_at = 20; run_frame(0); err_at = -1;
      chk("err_sticky", err, 1);
      chk("err_frame_sum", frame_sum, 38'd2080);
      @(negedge clk); err_clr = 1'b1; fifo_error = 1'b1;
      @(negedge clk); err_clr = 1'b0; fifo_error = 1'b0;
      #1 chk("err_set_wins", err, 1);
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      #1 chk("err_cleared", err, 0);

      // Reset after sample 20 with err set: everything clears without a clock edge.
      kind = 2; pat = 0; err_at = 5; run_frame(21); err_at = -1;
      chk("pre_rst_valid", m_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_rd_ce", fifo_rd_ce, 0);
      chk("arst_m_valid", m_valid, 0);
      chk("arst_m_data", m_data, 0);
      chk("arst_m_index", m_index, 0);
      chk("arst_first_last", {m_first, m_last}, 0);
      chk("arst_sum", frame_sum, 0);
      chk("arst_sum_valid", sum_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err, 0);
      pop_pend = 1'b0; prev_stall = 1'b0; fifo_error = 1'b0; loaded = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk("rst_hold_no_sum", sum_valid, 0);
      end
      rst = 1'b0;

      // Fresh frame after reset starts at index 0.
      kind = 0; rp = 128; run_frame(0);
      chk("post_rst_sum", frame_sum, 38'd2080);
      chk("post_rst_no_err", err, 0);

      // fifo_full held high: back-to-back frames, each with an idle gap and 64 pops.
      hold_full = 1; kind = 0; rp = 192;
      run_frame(0);
      chk("hold1_sum", frame_sum, 38'd2080);
      run_frame(0);
      chk("hold2_sum", frame_sum, 38'd2080);
      chk("full_in_flush_err", err, 1);
      hold_full = 0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
